// File: rtl/time_set_ctrl.sv
// time_set_ctrl: keypad-driven HHMMSS time-setting controller.
// Collects six BCD digits with per-digit range checks, then issues a
// one-cycle binary load of hour/minute/second into the time counters.
// Optional feature macro: TIME_SET_PRELOAD_EN. When it is defined, SET
// preloads the buffer from Cur_H/M/S, digits overwrite, and CONFIRM is
// accepted at any cursor position.
module time_set_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Key_flag,
  input  logic [3:0]  Key_Value,
`ifdef TIME_SET_PRELOAD_EN
  input  logic [4:0]  Cur_H,
  input  logic [5:0]  Cur_M,
  input  logic [5:0]  Cur_S,
`endif
  output logic        Edit_active,
  output logic [2:0]  Digit_pos,
  output logic [23:0] Edit_buf,
  output logic        Load_valid,
  output logic [4:0]  Load_H,
  output logic [5:0]  Load_M,
  output logic [5:0]  Load_S,
  output logic        Err_pulse
);

  localparam logic [3:0]  KEY_SET     = 4'd10;
  localparam logic [3:0]  KEY_BS      = 4'd11;
  localparam logic [3:0]  KEY_CONFIRM = 4'd12;
  localparam logic [3:0]  KEY_CANCEL  = 4'd13;
  localparam logic [31:0] CNT_LAST    = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_COMMIT} state_t;

  state_t      state_q, state_nx;
  logic [2:0]  pos_nx;
  logic [23:0] ebuf_nx;
  logic [31:0] cnt_q, cnt_nx;
  logic        err_nx;
  logic        digit_ok;
  logic [23:0] set_value;

  // Replace the nibble at cursor position pos (0 = H1 in bits [23:20]).
  function automatic logic [23:0] put_nibble(input logic [23:0] b,
                                             input logic [2:0]  pos,
                                             input logic [3:0]  val);
    logic [23:0] r;
    r = b;
    for (int i = 0; i < 6; i++)
      if (3'(i) == pos) r[(5-i)*4 +: 4] = val;
    return r;
  endfunction

  // Two BCD digits to binary.
  function automatic logic [6:0] bcd2bin(input logic [3:0] tens,
                                         input logic [3:0] ones);
    return 7'(tens) * 7'd10 + 7'(ones);
  endfunction

`ifdef TIME_SET_PRELOAD_EN
  // Binary 0..59 to two BCD digits by repeated compare-subtract of 10.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    for (int i = 0; i < 5; i++)
      if (r >= 6'd10) begin
        r = r - 6'd10;
        t = t + 4'd1;
      end
    return {t, r[3:0]};
  endfunction

  assign set_value = {to_bcd({1'b0, Cur_H}), to_bcd(Cur_M), to_bcd(Cur_S)};
`else
  assign set_value = 24'd0;
`endif

  // Per-position digit range check; the H0 limit depends on the H1 nibble.
  always_comb begin
    digit_ok = 1'b0;
    case (Digit_pos)
      3'd0:    digit_ok = (Key_Value <= 4'd2);
      3'd1:    digit_ok = (Edit_buf[23:20] == 4'd2) ? (Key_Value <= 4'd3) : 1'b1;
      3'd2:    digit_ok = (Key_Value <= 4'd5);
      3'd3:    digit_ok = 1'b1;
      3'd4:    digit_ok = (Key_Value <= 4'd5);
      3'd5:    digit_ok = 1'b1;
      default: digit_ok = 1'b0;
    endcase
  end

  // Next-state, edit buffer, cursor, inactivity counter and error decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nx = state_q;
    pos_nx   = Digit_pos;
    ebuf_nx  = Edit_buf;
    cnt_nx   = cnt_q;
    err_nx   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_nx = 32'd0;
        if (Key_flag && Key_Value == KEY_SET) begin
          state_nx = S_EDIT;
          ebuf_nx  = set_value;
          pos_nx   = 3'd0;
        end
      end
      S_EDIT: begin
        if (Key_flag) begin
          // A key always wins over a timeout on the same edge.
          cnt_nx = 32'd0;
          if (Key_Value <= 4'd9) begin
            if (Digit_pos < 3'd6 && digit_ok) begin
              ebuf_nx = put_nibble(Edit_buf, Digit_pos, Key_Value);
              pos_nx  = Digit_pos + 3'd1;
            end else begin
              err_nx = 1'b1;
            end
          end else begin
            case (Key_Value)
              KEY_SET: begin
                ebuf_nx = set_value;
                pos_nx  = 3'd0;
              end
              KEY_BS: begin
                if (Digit_pos != 3'd0) begin
                  pos_nx = Digit_pos - 3'd1;
`ifndef TIME_SET_PRELOAD_EN
                  ebuf_nx = put_nibble(Edit_buf, Digit_pos - 3'd1, 4'd0);
`endif
                end
              end
              KEY_CONFIRM: begin
`ifdef TIME_SET_PRELOAD_EN
                state_nx = S_COMMIT;
`else
                if (Digit_pos == 3'd6) state_nx = S_COMMIT;
                else                   err_nx   = 1'b1;
`endif
              end
              KEY_CANCEL: state_nx = S_IDLE;
              default: ;
            endcase
          end
        end else if (cnt_q == CNT_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = 32'd0;
        end else begin
          cnt_nx = cnt_q + 32'd1;
        end
      end
      S_COMMIT: begin
        // Keys arriving here are dropped.
        state_nx = S_IDLE;
        cnt_nx   = 32'd0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Control state, edit buffer, cursor, counter and registered flags.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      Digit_pos   <= 3'd0;
      Edit_buf    <= 24'd0;
      cnt_q       <= 32'd0;
      Err_pulse   <= 1'b0;
      Edit_active <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_nx;
      Digit_pos   <= pos_nx;
      Edit_buf    <= ebuf_nx;
      cnt_q       <= cnt_nx;
      Err_pulse   <= err_nx;
      Edit_active <= (state_nx == S_EDIT);
    end
  end

  // Load strobe and binary time values, captured on the cycle after COMMIT.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Load_valid <= 1'b0;
      Load_H     <= 5'd0;
      Load_M     <= 6'd0;
      Load_S     <= 6'd0;
    end else if (state_q == S_COMMIT) begin
      Load_valid <= 1'b1;
      Load_H     <= 5'(bcd2bin(Edit_buf[23:20], Edit_buf[19:16]));
      Load_M     <= 6'(bcd2bin(Edit_buf[15:12], Edit_buf[11:8]));
      Load_S     <= 6'(bcd2bin(Edit_buf[7:4],   Edit_buf[3:0]));
    end else begin
      Load_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: a table of single-cycle key vectors
// with expected registered outputs, plus hand-written timeout and reset
// sequences. Inputs change on the falling edge; outputs are checked there.
module tb_time_set_ctrl;

  localparam logic [3:0] K_SET = 4'd10;
  localparam logic [3:0] K_BS  = 4'd11;
  localparam logic [3:0] K_CNF = 4'd12;
  localparam logic [3:0] K_CAN = 4'd13;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Key_flag;
  logic [3:0]  Key_Value;
  logic        Edit_active;
  logic [2:0]  Digit_pos;
  logic [23:0] Edit_buf;
  logic        Load_valid;
  logic [4:0]  Load_H;
  logic [5:0]  Load_M;
  logic [5:0]  Load_S;
  logic        Err_pulse;
`ifdef TIME_SET_PRELOAD_EN
  logic [4:0]  Cur_H = 5'd9;
  logic [5:0]  Cur_M = 6'd7;
  logic [5:0]  Cur_S = 6'd45;
`endif

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        flag;
    logic [3:0]  key;
    logic        act;
    logic [2:0]  pos;
    logic [23:0] ebuf;
    logic        err;
    logic        lv;
    logic [4:0]  h;
    logic [5:0]  m;
    logic [5:0]  s;
  } vec_t;

  vec_t vecs[$];

  time_set_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Key_flag    (Key_flag),
    .Key_Value   (Key_Value),
`ifdef TIME_SET_PRELOAD_EN
    .Cur_H       (Cur_H),
    .Cur_M       (Cur_M),
    .Cur_S       (Cur_S),
`endif
    .Edit_active (Edit_active),
    .Digit_pos   (Digit_pos),
    .Edit_buf    (Edit_buf),
    .Load_valid  (Load_valid),
    .Load_H      (Load_H),
    .Load_M      (Load_M),
    .Load_S      (Load_S),
    .Err_pulse   (Err_pulse)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic flag, input logic [3:0] key, input logic act,
                     input logic [2:0] pos, input logic [23:0] ebuf, input logic err,
                     input logic lv, input logic [4:0] h, input logic [5:0] m,
                     input logic [5:0] s);
    vecs.push_back('{flag, key, act, pos, ebuf, err, lv, h, m, s});
  endtask

  // Present one key for one rising edge; returns on the following falling edge.
  task automatic press(input logic [3:0] k);
    Key_flag  = 1'b1;
    Key_Value = k;
    @(negedge Clk);
    Key_flag  = 1'b0;
    Key_Value = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check_state(input string tag, input logic act, input logic [2:0] pos,
                             input logic [23:0] ebuf);
    check({tag, ".active"}, Edit_active, act);
    check({tag, ".pos"}, Digit_pos, pos);
    check({tag, ".buf"}, Edit_buf, ebuf);
  endtask

  task automatic check_zero(input string tag);
    check_state(tag, 1'b0, 3'd0, 24'h0);
    check({tag, ".lv"}, Load_valid, 0);
    check({tag, ".err"}, Err_pulse, 0);
    check({tag, ".h"}, Load_H, 0);
    check({tag, ".m"}, Load_M, 0);
    check({tag, ".s"}, Load_S, 0);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    idle(2);
    Rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    Rst_n     = 1'b0;
    Key_flag  = 1'b0;
    Key_Value = 4'd0;
    idle(1);
    check_zero("in_reset");
    do_reset();
    check_zero("after_reset");

`ifdef TIME_SET_PRELOAD_EN
    // Preload from the running time, confirm immediately.
    press(K_SET);
    check_state("pre_set", 1'b1, 3'd0, 24'h090745);
    press(K_CNF);
    check("pre_cnf.active", Edit_active, 0);
    check("pre_cnf.lv", Load_valid, 0);
    idle(1);
    check("pre_load.lv", Load_valid, 1);
    check("pre_load.h", Load_H, 9);
    check("pre_load.m", Load_M, 7);
    check("pre_load.s", Load_S, 45);
    idle(1);
    check("pre_load2.lv", Load_valid, 0);
    // Overwrite then backspace: cursor moves back, nibble kept.
    press(K_SET);
    press(4'd1);
    check_state("pre_ovw", 1'b1, 3'd1, 24'h190745);
    press(K_BS);
    check_state("pre_bs", 1'b1, 3'd0, 24'h190745);
    press(K_BS);
    check_state("pre_bs0", 1'b1, 3'd0, 24'h190745);
    check("pre_bs0.err", Err_pulse, 0);
    press(K_CAN);
    check("pre_can.active", Edit_active, 0);
`else
    // Entry 12:34:56 and commit.
    add(1, K_SET, 1, 0, 24'h000000, 0, 0, 0, 0, 0);
    add(1, 4'd1,  1, 1, 24'h100000, 0, 0, 0, 0, 0);
    add(1, 4'd2,  1, 2, 24'h120000, 0, 0, 0, 0, 0);
    add(1, 4'd3,  1, 3, 24'h123000, 0, 0, 0, 0, 0);
    add(1, 4'd4,  1, 4, 24'h123400, 0, 0, 0, 0, 0);
    add(1, 4'd5,  1, 5, 24'h123450, 0, 0, 0, 0, 0);
    add(1, 4'd6,  1, 6, 24'h123456, 0, 0, 0, 0, 0);
    add(1, K_CNF, 0, 6, 24'h123456, 0, 0, 0, 0, 0);
    add(0, 4'd0,  0, 6, 24'h123456, 0, 1, 12, 34, 56);
    add(0, 4'd0,  0, 6, 24'h123456, 0, 0, 12, 34, 56);
    // 23:59:59 with a rejected H0=4.
    add(1, K_SET, 1, 0, 24'h000000, 0, 0, 12, 34, 56);
    add(1, 4'd2,  1, 1, 24'h200000, 0, 0, 12, 34, 56);
    add(1, 4'd4,  1, 1, 24'h200000, 1, 0, 12, 34, 56);
    add(1, 4'd3,  1, 2, 24'h230000, 0, 0, 12, 34, 56);
    add(1, 4'd5,  1, 3, 24'h235000, 0, 0, 12, 34, 56);
    add(1, 4'd9,  1, 4, 24'h235900, 0, 0, 12, 34, 56);
    add(1, 4'd5,  1, 5, 24'h235950, 0, 0, 12, 34, 56);
    add(1, 4'd9,  1, 6, 24'h235959, 0, 0, 12, 34, 56);
    add(1, K_CNF, 0, 6, 24'h235959, 0, 0, 12, 34, 56);
    add(0, 4'd0,  0, 6, 24'h235959, 0, 1, 23, 59, 59);
    add(0, 4'd0,  0, 6, 24'h235959, 0, 0, 23, 59, 59);
    // Early confirm, backspace past zero, cancel, keys ignored in IDLE.
    add(1, K_SET, 1, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(1, 4'd1,  1, 1, 24'h100000, 0, 0, 23, 59, 59);
    add(1, 4'd2,  1, 2, 24'h120000, 0, 0, 23, 59, 59);
    add(1, K_CNF, 1, 2, 24'h120000, 1, 0, 23, 59, 59);
    add(1, K_BS,  1, 1, 24'h100000, 0, 0, 23, 59, 59);
    add(1, K_BS,  1, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(1, K_BS,  1, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(1, K_CAN, 0, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(0, 4'd0,  0, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(1, 4'd5,  0, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(1, K_CNF, 0, 0, 24'h000000, 0, 0, 23, 59, 59);
    // Range rules: H1=3 rejected, H0=9 allowed when H1=1, M1=6 rejected.
    add(1, K_SET, 1, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(1, 4'd3,  1, 0, 24'h000000, 1, 0, 23, 59, 59);
    add(1, 4'd1,  1, 1, 24'h100000, 0, 0, 23, 59, 59);
    add(1, 4'd9,  1, 2, 24'h190000, 0, 0, 23, 59, 59);
    add(1, 4'd6,  1, 2, 24'h190000, 1, 0, 23, 59, 59);
    add(1, 4'd14, 1, 2, 24'h190000, 0, 0, 23, 59, 59);
    add(1, K_CAN, 0, 2, 24'h190000, 0, 0, 23, 59, 59);
    // SET inside EDIT restarts the entry.
    add(1, K_SET, 1, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(1, 4'd2,  1, 1, 24'h200000, 0, 0, 23, 59, 59);
    add(1, K_SET, 1, 0, 24'h000000, 0, 0, 23, 59, 59);
    add(1, K_CAN, 0, 0, 24'h000000, 0, 0, 23, 59, 59);

    foreach (vecs[i]) begin
      Key_flag  = vecs[i].flag;
      Key_Value = vecs[i].key;
      @(negedge Clk);
      Key_flag  = 1'b0;
      Key_Value = 4'd0;
      check($sformatf("v%0d.active", i), Edit_active, vecs[i].act);
      check($sformatf("v%0d.pos", i),    Digit_pos,   vecs[i].pos);
      check($sformatf("v%0d.buf", i),    Edit_buf,    vecs[i].ebuf);
      check($sformatf("v%0d.err", i),    Err_pulse,   vecs[i].err);
      check($sformatf("v%0d.lv", i),     Load_valid,  vecs[i].lv);
      check($sformatf("v%0d.h", i),      Load_H,      vecs[i].h);
      check($sformatf("v%0d.m", i),      Load_M,      vecs[i].m);
      check($sformatf("v%0d.s", i),      Load_S,      vecs[i].s);
    end

    // Timeout: 100 quiet edges after the last key abandon the entry.
    press(K_SET);
    press(4'd0);
    idle(99);
    check_state("to1_99", 1'b1, 3'd1, 24'h000000);
    idle(1);
    check_state("to1_100", 1'b0, 3'd1, 24'h000000);
    check("to1_100.err", Err_pulse, 0);
    check("to1_100.lv", Load_valid, 0);
    idle(1);
    check("to1_101.lv", Load_valid, 0);

    // A key on quiet edge 99 restarts the count.
    press(K_SET);
    press(4'd0);
    idle(98);
    press(4'd1);
    idle(99);
    check_state("to2_99", 1'b1, 3'd2, 24'h010000);
    idle(1);
    check_state("to2_100", 1'b0, 3'd2, 24'h010000);

    // A key on the very edge the timeout would fire wins.
    press(K_SET);
    idle(99);
    press(4'd1);
    check_state("to3_key", 1'b1, 3'd1, 24'h100000);
    idle(99);
    check("to3_99.active", Edit_active, 1);
    idle(1);
    check("to3_100.active", Edit_active, 0);

    // Reset during COMMIT suppresses the load strobe.
    press(K_SET);
    for (int d = 1; d <= 6; d++) press(4'(d));
    press(K_CNF);
    check("rc_commit.active", Edit_active, 0);
    Rst_n = 1'b0;
    #1;
    check_zero("rc_async");
    idle(1);
    check_zero("rc_next");
    Rst_n = 1'b1;
    idle(1);

    // Full zero entry, extra digit rejected, reset before CONFIRM.
    press(K_SET);
    for (int d = 0; d < 6; d++) press(4'd0);
    check_state("z6", 1'b1, 3'd6, 24'h000000);
    press(4'd5);
    check_state("z7", 1'b1, 3'd6, 24'h000000);
    check("z7.err", Err_pulse, 1);
    Rst_n = 1'b0;
    idle(1);
    Rst_n = 1'b1;
    check_zero("z_rst");
    press(K_CNF);
    check_zero("z_cnf");
    idle(1);
    check_zero("z_after");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
